// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
//   Single-channel SPI bus master. Serialises one byte at a time MSB-first on
//   mosi while capturing miso, in any CPOL/CPHA mode, with a programmable SCK
//   half-period. Bytes come either from a direct start/data_tx request or from
//   an 8-deep TX FIFO (bursts keep chip select asserted). Received bytes land
//   in data_rx and in an 8-deep show-ahead RX FIFO.
//
// Ports
//   clk, reset           : system clock, asynchronous active-high reset
//   start, data_tx       : single-byte transfer request and its payload
//   cpol_cpha            : [1]=CPOL, [0]=CPHA, latched when a transfer starts
//   clk_div              : SCK half-period in clk cycles (0 behaves as 1)
//   cs_polarity          : 0 = active-low chip selects, 1 = active-high
//   cs_select            : which cs_n bit is driven active
//   loopback             : receive path taken from internal mosi instead of miso
//   miso                 : serial data from the slave
//   fifo_write_en/_in    : TX FIFO push
//   fifo_read_en         : RX FIFO pop
//   data_rx              : last received byte
//   busy, done, error    : status; done/error are one-cycle pulses
//   tx/rx_fifo_full/empty: FIFO status flags
//   fifo_data_out        : RX FIFO head, 0 when empty
//   sck, mosi, cs_n      : SPI bus
//   irq                  : one-cycle pulse at burst end or on any error
// -----------------------------------------------------------------------------
module spi_master #(
  parameter int CLK_DIV_WIDTH = 8,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [7:0]               data_tx,
  input  logic [1:0]               cpol_cpha,
  input  logic [CLK_DIV_WIDTH-1:0] clk_div,
  input  logic                     cs_polarity,
  input  logic [1:0]               cs_select,
  input  logic                     loopback,
  input  logic                     miso,
  input  logic                     fifo_write_en,
  input  logic [7:0]               fifo_data_in,
  input  logic                     fifo_read_en,
  output logic [7:0]               data_rx,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic                     tx_fifo_full,
  output logic                     tx_fifo_empty,
  output logic                     rx_fifo_full,
  output logic                     rx_fifo_empty,
  output logic [7:0]               fifo_data_out,
  output logic                     sck,
  output logic                     mosi,
  output logic [3:0]               cs_n,
  output logic                     irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_COUNT = FIFO_DEPTH[AW:0];

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} spiState_t;

  spiState_t                r_state;
  logic [CLK_DIV_WIDTH-1:0] r_cnt;
  logic [CLK_DIV_WIDTH-1:0] r_halfM1;
  logic [4:0]               r_edge;
  logic                     r_cpha;
  logic [7:0]               r_txShift;
  logic [7:0]               r_rxShift;
  logic [7:0]               r_dataRx;
  logic                     r_sck;
  logic                     r_mosi;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_error;
  logic                     r_irq;
  logic [3:0]               r_csOneHot;

  logic [7:0]               r_txMem [FIFO_DEPTH];
  logic [AW-1:0]            r_txRd;
  logic [AW-1:0]            r_txWr;
  logic [AW:0]              r_txCount;
  logic [7:0]               r_rxMem [FIFO_DEPTH];
  logic [AW-1:0]            r_rxRd;
  logic [AW-1:0]            r_rxWr;
  logic [AW:0]              r_rxCount;

  logic                     w_tick;
  logic                     w_txEmpty;
  logic                     w_txFull;
  logic                     w_rxEmpty;
  logic                     w_rxFull;
  logic [CLK_DIV_WIDTH-1:0] w_divM1;
  logic                     w_idleFifo;
  logic                     w_holdExit;
  logic                     w_txPop;
  logic                     w_txPush;
  logic                     w_rxPop;
  logic                     w_rxPush;
  logic                     w_errAny;
  logic [7:0]               w_txHead;
  logic [7:0]               w_startByte;
  logic [4:0]               w_edgeNum;
  logic                     w_sampleEdge;
  logic                     w_inBit;

  // Half-period countdown: each phase reloads H-1 and acts when it reaches 0.
  assign w_tick       = (r_cnt == '0);
  assign w_divM1      = (clk_div == '0) ? '0 : clk_div - CLK_DIV_WIDTH'(1);
  assign w_txEmpty    = (r_txCount == '0);
  assign w_txFull     = (r_txCount == DEPTH_COUNT);
  assign w_rxEmpty    = (r_rxCount == '0);
  assign w_rxFull     = (r_rxCount == DEPTH_COUNT);
  assign w_txHead     = r_txMem[r_txRd];
  assign w_startByte  = start ? data_tx : w_txHead;
  assign w_idleFifo   = (r_state == IDLE) && !start && !w_txEmpty;
  assign w_holdExit   = (r_state == HOLD) && w_tick;

  // A pop in the same cycle frees a slot, so a write or push to a full FIFO
  // still succeeds then.
  assign w_txPop      = w_idleFifo || (w_holdExit && !w_txEmpty);
  assign w_txPush     = fifo_write_en && (!w_txFull || w_txPop);
  assign w_rxPop      = fifo_read_en && !w_rxEmpty;
  assign w_rxPush     = w_holdExit && (!w_rxFull || w_rxPop);

  assign w_errAny     = (start && (r_state != IDLE))
                      || (fifo_write_en && !w_txPush)
                      || (fifo_read_en && w_rxEmpty)
                      || (w_holdExit && !w_rxPush);

  // Odd edges are leading edges; CPHA=0 samples on them, CPHA=1 on trailing.
  assign w_edgeNum    = r_edge + 5'd1;
  assign w_sampleEdge = (w_edgeNum[0] != r_cpha);
  assign w_inBit      = loopback ? r_mosi : miso;

  // Transfer engine: IDLE picks up a start or a queued byte, SETUP holds CS
  // and bit 7 for one half-period, SHIFT walks the 16 SCK edges, HOLD keeps CS
  // for one more half-period before delivering the byte and either chaining
  // the next queued byte or releasing the bus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_halfM1   <= '0;
      r_edge     <= '0;
      r_cpha     <= 1'b0;
      r_txShift  <= '0;
      r_rxShift  <= '0;
      r_dataRx   <= '0;
      r_sck      <= 1'b0;
      r_mosi     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_csOneHot <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_sck <= cpol_cpha[1];
          if (start || !w_txEmpty) begin
            r_state    <= SETUP;
            r_busy     <= 1'b1;
            r_cpha     <= cpol_cpha[0];
            r_halfM1   <= w_divM1;
            r_cnt      <= w_divM1;
            r_csOneHot <= 4'b0001 << cs_select;
            r_txShift  <= w_startByte;
            r_mosi     <= w_startByte[7];
            r_rxShift  <= '0;
            r_edge     <= '0;
          end
        end
        SETUP, SHIFT: begin
          if (w_tick) begin
            r_sck  <= ~r_sck;
            r_edge <= w_edgeNum;
            r_cnt  <= r_halfM1;
            if (w_sampleEdge) begin
              r_rxShift <= {r_rxShift[6:0], w_inBit};
            end else if (r_cpha) begin
              r_mosi    <= r_txShift[7];
              r_txShift <= {r_txShift[6:0], 1'b0};
            end else if (w_edgeNum != 5'd16) begin
              r_mosi    <= r_txShift[6];
              r_txShift <= {r_txShift[6:0], 1'b0};
            end
            r_state <= (w_edgeNum == 5'd16) ? HOLD : SHIFT;
          end else begin
            r_cnt <= r_cnt - CLK_DIV_WIDTH'(1);
          end
        end
        HOLD: begin
          if (w_tick) begin
            r_dataRx <= r_rxShift;
            r_done   <= 1'b1;
            if (!w_txEmpty) begin
              r_state   <= SETUP;
              r_cnt     <= r_halfM1;
              r_txShift <= w_txHead;
              r_mosi    <= w_txHead[7];
              r_rxShift <= '0;
              r_edge    <= '0;
            end else begin
              r_state    <= IDLE;
              r_busy     <= 1'b0;
              r_csOneHot <= '0;
            end
          end else begin
            r_cnt <= r_cnt - CLK_DIV_WIDTH'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Error and interrupt pulses; irq fires at the end of a burst and alongside
  // every error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_error <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      r_error <= w_errAny;
      r_irq   <= w_errAny || (w_holdExit && w_txEmpty);
    end
  end

  // FIFO storage needs no reset; resetting the pointers flushes both queues.
  always_ff @(posedge clk) begin
    if (w_txPush) r_txMem[r_txWr] <= fifo_data_in;
    if (w_rxPush) r_rxMem[r_rxWr] <= r_rxShift;
  end

  // TX FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_txRd    <= '0;
      r_txWr    <= '0;
      r_txCount <= '0;
    end else begin
      if (w_txPush) r_txWr <= r_txWr + 1'b1;
      if (w_txPop)  r_txRd <= r_txRd + 1'b1;
      case ({w_txPush, w_txPop})
        2'b10:   r_txCount <= r_txCount + 1'b1;
        2'b01:   r_txCount <= r_txCount - 1'b1;
        default: r_txCount <= r_txCount;
      endcase
    end
  end

  // RX FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rxRd    <= '0;
      r_rxWr    <= '0;
      r_rxCount <= '0;
    end else begin
      if (w_rxPush) r_rxWr <= r_rxWr + 1'b1;
      if (w_rxPop)  r_rxRd <= r_rxRd + 1'b1;
      case ({w_rxPush, w_rxPop})
        2'b10:   r_rxCount <= r_rxCount + 1'b1;
        2'b01:   r_rxCount <= r_rxCount - 1'b1;
        default: r_rxCount <= r_rxCount;
      endcase
    end
  end

  // cs_n is kept as a one-hot "active" mask so the inactive level follows
  // cs_polarity even while reset is held.
  assign cs_n          = r_csOneHot ^ {4{~cs_polarity}};
  assign sck           = r_sck;
  assign mosi          = r_mosi;
  assign busy          = r_busy;
  assign done          = r_done;
  assign error         = r_error;
  assign irq           = r_irq;
  assign data_rx       = r_dataRx;
  assign tx_fifo_full  = w_txFull;
  assign tx_fifo_empty = w_txEmpty;
  assign rx_fifo_full  = w_rxFull;
  assign rx_fifo_empty = w_rxEmpty;
  assign fifo_data_out = w_rxEmpty ? 8'h00 : r_rxMem[r_rxRd];

endmodule

// File: tb/tb_spi_master.sv
// -----------------------------------------------------------------------------
// tb_spi_master
//   Self-checking bench for spi_master. A behavioural SPI slave watches the
//   bus at the falling clk edge, shifts out a chosen reply byte and records
//   the bits it sees on mosi. Expected results (latency 1+17*H, received byte,
//   idle levels, FIFO contents) come from plain arithmetic and queues here.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_master;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] data_tx = 8'h00;
  logic [1:0] cpol_cpha = 2'd0;
  logic [7:0] clk_div = 8'd1;
  logic       cs_polarity = 1'b0;
  logic [1:0] cs_select = 2'd0;
  logic       loopback = 1'b0;
  logic       miso = 1'b0;
  logic       fifo_write_en = 1'b0;
  logic [7:0] fifo_data_in = 8'h00;
  logic       fifo_read_en = 1'b0;

  logic [7:0] data_rx;
  logic       busy;
  logic       done;
  logic       error;
  logic       tx_fifo_full;
  logic       tx_fifo_empty;
  logic       rx_fifo_full;
  logic       rx_fifo_empty;
  logic [7:0] fifo_data_out;
  logic       sck;
  logic       mosi;
  logic [3:0] cs_n;
  logic       irq;

  int checkCount = 0;
  int errorCount = 0;

  logic [7:0] slaveByte = 8'h00;
  logic [7:0] slaveRx = 8'h00;
  int         slaveIdx = 0;
  logic       tbCpol = 1'b0;
  logic       tbCpha = 1'b0;
  logic       prevSck = 1'b0;
  logic       prevCsAct = 1'b0;
  int         leadCount = 0;
  int         doneCount = 0;
  int         irqCount = 0;

  always #5 clk = ~clk;

  spi_master #(.CLK_DIV_WIDTH(8), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .data_tx(data_tx),
    .cpol_cpha(cpol_cpha), .clk_div(clk_div), .cs_polarity(cs_polarity),
    .cs_select(cs_select), .loopback(loopback), .miso(miso),
    .fifo_write_en(fifo_write_en), .fifo_data_in(fifo_data_in),
    .fifo_read_en(fifo_read_en), .data_rx(data_rx), .busy(busy), .done(done),
    .error(error), .tx_fifo_full(tx_fifo_full), .tx_fifo_empty(tx_fifo_empty),
    .rx_fifo_full(rx_fifo_full), .rx_fifo_empty(rx_fifo_empty),
    .fifo_data_out(fifo_data_out), .sck(sck), .mosi(mosi), .cs_n(cs_n), .irq(irq)
  );

  // Behavioural slave plus pulse counters. Runs on the falling edge, so the
  // DUT outputs registered on the previous rising edge are stable here.
  always @(negedge clk) begin : slaveMonitor
    logic csAct;
    logic leading;
    csAct = (cs_n[cs_select] == cs_polarity);
    if (reset) begin
      prevCsAct = 1'b0;
      prevSck   = sck;
    end else begin
      if (done) doneCount++;
      if (irq)  irqCount++;
      if (csAct && !prevCsAct) begin
        slaveRx = 8'h00;
        if (tbCpha) begin
          slaveIdx = 7;
        end else begin
          miso     = slaveByte[7];
          slaveIdx = 6;
        end
      end else if (csAct && (sck != prevSck)) begin
        leading = (sck != tbCpol);
        if (leading) leadCount++;
        if (leading != tbCpha) begin
          slaveRx = {slaveRx[6:0], mosi};
        end else if (slaveIdx >= 0) begin
          miso = slaveByte[slaveIdx];
          slaveIdx--;
        end
      end
      prevCsAct = csAct;
      prevSck   = sck;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // All bench activity happens 1ns after the falling edge.
  task automatic waitCycle();
    @(negedge clk);
    #1;
  endtask

  task automatic applyReset();
    reset = 1'b1;
    waitCycle();
    waitCycle();
    reset = 1'b0;
    waitCycle();
  endtask

  // One single-byte transfer via start; optionally fires a second start at
  // cycle intrudeCycle to exercise the busy-start error.
  task automatic applyStimulus(input logic [7:0] txByte, input logic [1:0] mode,
                               input logic [7:0] div, input logic lb,
                               input logic [1:0] sel, input logic pol,
                               input logic [7:0] slaveData, input int intrudeCycle);
    int         cycles;
    int         limit;
    int         expLat;
    logic [7:0] expRx;
    logic [3:0] activePat;
    logic [3:0] idlePat;
    logic       csBad;
    expLat    = 1 + 17 * ((div == 8'd0) ? 1 : int'(div));
    expRx     = lb ? txByte : slaveData;
    activePat = pol ? (4'b0001 << sel) : ~(4'b0001 << sel);
    idlePat   = pol ? 4'b0000 : 4'b1111;
    waitCycle();
    data_tx = txByte; cpol_cpha = mode; clk_div = div; loopback = lb;
    cs_select = sel; cs_polarity = pol;
    tbCpol = mode[1]; tbCpha = mode[0]; slaveByte = slaveData; leadCount = 0;
    start = 1'b1;
    waitCycle();
    start = 1'b0;
    cycles = 1;
    csBad = 1'b0;
    checkOutput("busyAfterStart", busy, 1);
    checkOutput("csActive", cs_n, activePat);
    limit = expLat + 50;
    while (!done && cycles < limit) begin
      if (cycles == intrudeCycle) begin
        start = 1'b1;
        data_tx = ~txByte;
      end
      waitCycle();
      cycles++;
      if (start) begin
        start = 1'b0;
        checkOutput("errorOnBusyStart", error, 1);
      end
      if (!done && cs_n !== activePat) csBad = 1'b1;
    end
    checkOutput("doneLatency", cycles, expLat);
    checkOutput("dataRx", data_rx, expRx);
    checkOutput("busyLowAtDone", busy, 0);
    checkOutput("irqAtEnd", irq, 1);
    checkOutput("sckIdleCpol", sck, mode[1]);
    checkOutput("csIdle", cs_n, idlePat);
    checkOutput("csHeld", csBad, 0);
    checkOutput("sckPulses", leadCount, 8);
    checkOutput("slaveSawMosi", slaveRx, txByte);
    checkOutput("rxFifoHead", fifo_data_out, expRx);
    fifo_read_en = 1'b1;
    waitCycle();
    fifo_read_en = 1'b0;
    checkOutput("rxFifoDrained", rx_fifo_empty, 1);
  endtask

  // Three queued bytes in one burst with loopback.
  task automatic runBurst();
    logic [7:0] q[$];
    int         doneBefore;
    int         irqBefore;
    int         cycles;
    logic       csBad;
    q = '{8'h01, 8'h02, 8'h03};
    waitCycle();
    loopback = 1'b1; cpol_cpha = 2'($urandom_range(0, 3)); clk_div = 8'd2;
    cs_select = 2'd1; cs_polarity = 1'b0;
    tbCpol = cpol_cpha[1]; tbCpha = cpol_cpha[0];
    doneBefore = doneCount;
    irqBefore = irqCount;
    foreach (q[i]) begin
      fifo_write_en = 1'b1;
      fifo_data_in = q[i];
      waitCycle();
    end
    fifo_write_en = 1'b0;
    cycles = 0;
    csBad = 1'b0;
    while (busy && cycles < 500) begin
      if (cs_n !== 4'b1101) csBad = 1'b1;
      waitCycle();
      cycles++;
    end
    checkOutput("burstFinished", busy, 0);
    checkOutput("burstDoneCount", doneCount - doneBefore, 3);
    checkOutput("burstIrqCount", irqCount - irqBefore, 1);
    checkOutput("burstCsHeld", csBad, 0);
    foreach (q[i]) begin
      checkOutput("burstRxFifo", fifo_data_out, q[i]);
      fifo_read_en = 1'b1;
      waitCycle();
      fifo_read_en = 1'b0;
    end
    checkOutput("burstRxEmpty", rx_fifo_empty, 1);
  endtask

  // Fill the TX FIFO behind a long transfer, then abort with reset.
  task automatic runFillTest();
    waitCycle();
    loopback = 1'b1; cpol_cpha = 2'd0; clk_div = 8'd255; cs_select = 2'd0;
    cs_polarity = 1'b0; tbCpol = 1'b0; tbCpha = 1'b0;
    data_tx = 8'h3C; start = 1'b1;
    waitCycle();
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      fifo_write_en = 1'b1;
      fifo_data_in = 8'($urandom);
      waitCycle();
      if (i == 0) checkOutput("noErrorOnWrite", error, 0);
      if (i == 6) checkOutput("txNotFullAt7", tx_fifo_full, 0);
      if (i == 7) checkOutput("txFullAfter8", tx_fifo_full, 1);
      if (i == 8) checkOutput("errorOnFullWrite", error, 1);
    end
    fifo_write_en = 1'b0;
    applyReset();
    checkOutput("txFlushedByReset", tx_fifo_empty, 1);
    checkOutput("idleAfterFlush", busy, 0);
  endtask

  // Reset asserted right after SCK edge 7 (H=3 so edge 7 shows at cycle 22).
  task automatic runResetAbort();
    int doneBefore;
    waitCycle();
    loopback = 1'b1; cpol_cpha = 2'd0; clk_div = 8'd3; cs_select = 2'd0;
    cs_polarity = 1'b0; tbCpol = 1'b0; tbCpha = 1'b0;
    data_tx = 8'h5A; start = 1'b1;
    waitCycle();
    start = 1'b0;
    repeat (20) waitCycle();
    checkOutput("sckBeforeEdge7", sck, 0);
    waitCycle();
    checkOutput("sckAtEdge7", sck, 1);
    doneBefore = doneCount;
    reset = 1'b1;
    #1;
    checkOutput("abortBusy", busy, 0);
    checkOutput("abortCs", cs_n, 4'hF);
    checkOutput("abortSck", sck, 0);
    waitCycle();
    waitCycle();
    reset = 1'b0;
    repeat (60) waitCycle();
    checkOutput("noDoneAfterAbort", doneCount - doneBefore, 0);
  endtask

  initial begin
    reset = 1'b1;
    waitCycle();
    waitCycle();
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstDone", done, 0);
    checkOutput("rstError", error, 0);
    checkOutput("rstIrq", irq, 0);
    checkOutput("rstMosi", mosi, 0);
    checkOutput("rstSck", sck, 0);
    checkOutput("rstCs", cs_n, 4'hF);
    checkOutput("rstDataRx", data_rx, 0);
    checkOutput("rstFifoOut", fifo_data_out, 0);
    checkOutput("rstFlags", {tx_fifo_full, tx_fifo_empty, rx_fifo_full, rx_fifo_empty}, 4'b0101);
    reset = 1'b0;
    waitCycle();

    applyStimulus(8'hA5, 2'd0, 8'd4, 1'b1, 2'd0, 1'b0, 8'h00, 0);

    for (int m = 0; m < 4; m++) begin
      applyStimulus(8'hAA, 2'(m), 8'(m), 1'b0, 2'(m), 1'b0, 8'h55, 0);
    end

    applyStimulus(8'h96, 2'd1, 8'd3, 1'b1, 2'd2, 1'b1, 8'h00, 5);

    for (int n = 0; n < 6; n++) begin
      applyStimulus(8'($urandom), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 6)),
                    1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 8'($urandom), 0);
    end

    runBurst();
    runFillTest();
    runResetAbort();
    applyStimulus(8'hC3, 2'd2, 8'd2, 1'b0, 2'd3, 1'b0, 8'h3E, 0);

    waitCycle();
    fifo_read_en = 1'b1;
    waitCycle();
    fifo_read_en = 1'b0;
    checkOutput("errorOnEmptyRead", error, 1);
    checkOutput("irqOnError", irq, 1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/spi_master.md
# spi_master

Single-channel SPI bus master: serialises one byte at a time MSB-first on MOSI while capturing MISO, in any of the four CPOL/CPHA modes, with a programmable SCK divider. It sits between a register/bus front end and off-chip SPI slaves. It accepts direct single-byte transfers (`start`/`data_tx`) or burst transfers queued through an 8-deep TX FIFO. Received bytes go to `data_rx` and to an 8-deep RX FIFO.

## Interface
- `CLK_DIV_WIDTH`, 8: width of `clk_div`.
- `FIFO_DEPTH`, 8: entries in each of the TX and RX FIFOs (power of two).
- `clk` in 1: system clock. All logic is in this single clock domain.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request to send `data_tx` (single-byte transfer).
- `data_tx` in 8: byte to send on `start`.
- `cpol_cpha` in 2: [1]=CPOL, [0]=CPHA; latched at transfer start.
- `clk_div` in CLK_DIV_WIDTH: SCK half-period in clk cycles; 0 is treated as 1; latched at transfer start.
- `cs_polarity` in 1: 0 = chip selects active-low, 1 = active-high.
- `cs_select` in 2: selects which `cs_n` bit is driven active; latched at transfer start.
- `loopback` in 1: 1 = internal MOSI→receive path, external `miso` ignored.
- `miso` in 1: serial data from slave.
- `fifo_write_en` in 1: push `fifo_data_in` into TX FIFO.
- `fifo_data_in` in 8: TX FIFO write data.
- `fifo_read_en` in 1: pop RX FIFO.
- `data_rx` out 8: last received byte.
- `busy` out 1: transfer or burst in progress.
- `done` out 1: one-cycle pulse per completed byte.
- `error` out 1: one-cycle pulse on a protocol misuse.
- `tx_fifo_full` out 1, `tx_fifo_empty` out 1, `rx_fifo_full` out 1, `rx_fifo_empty` out 1: FIFO status flags.
- `fifo_data_out` out 8: RX FIFO head (show-ahead); 0 when the FIFO is empty.
- `sck` out 1, `mosi` out 1: SPI clock and data out.
- `cs_n` out 4: chip selects; only bit `cs_select` goes active.
- `irq` out 1: one-cycle interrupt pulse.

## Operation
- States: IDLE, SETUP, SHIFT, HOLD.
- IDLE behaviour:
  - `sck` = CPOL.
  - All `cs_n` bits at the inactive level (~`cs_polarity`).
  - `mosi` holds its last value.
- Leaving IDLE:
  - `start` → latch `data_tx`.
  - Otherwise, if the TX FIFO is not empty, pop its head.
  - `start` has priority over a non-empty TX FIFO.
  - On either trigger, latch mode, divider and select, then enter SETUP.
- SETUP:
  - The selected CS goes active.
  - MOSI = bit 7.
  - Lasts H = max(`clk_div`,1) cycles.
- SHIFT: 16 SCK edges, H cycles apart.
  - CPHA=0: sample on odd (leading) edges; drive the next bit on even (trailing) edges.
  - CPHA=1: drive on leading edges (bit 7 on the first); sample on trailing edges.
- After the 16th edge, `sck` = CPOL and the block enters HOLD.
- HOLD (H cycles), then on exit:
  - `data_rx` is updated.
  - The byte is pushed to the RX FIFO.
  - `done` pulses.
- After HOLD:
  - TX FIFO non-empty → pop it and go back to SETUP with CS kept active (burst).
  - TX FIFO empty → CS goes inactive, `busy` drops, `irq` pulses, return to IDLE.
- `loopback`=1: the sampled bit is the internal MOSI, so the received byte equals the transmitted byte.
- `error` pulses for any of:
  - `start` while `busy`; the request is ignored.
  - TX FIFO write while full; the data is dropped.
  - RX FIFO read while empty.
  - RX push while full; the new byte is dropped, but `data_rx` is still updated.
- `irq` also pulses with every `error` pulse.
- Simultaneous push and pop on one FIFO are both performed. A write to a full TX FIFO in the same cycle as an engine pop succeeds.

## Timing
- Reset values:
  - `busy`, `done`, `error`, `irq`, `mosi` = 0.
  - `data_rx`, `fifo_data_out` = 0.
  - `tx_fifo_empty`, `rx_fifo_empty` = 1; `tx_fifo_full`, `rx_fifo_full` = 0.
  - Both FIFOs are flushed.
  - `sck` = 0 during reset, then CPOL.
  - `cs_n` = inactive level throughout reset.
- `start` is sampled at clk edge T0. At T0+1: `busy`=1 and the CS is active.
- Edge k (1..16) occurs at T0+1+k·H.
- At T0+1+17·H: `done`=1, `data_rx` is valid and `busy`=0 (single byte).
  - Example: `clk_div`=4 gives 69 cycles from `start` to `done`.
- In a burst, the next SETUP begins the cycle after `done`.
- All outputs are registered.
- Reset asserted mid-transfer aborts immediately: outputs take their reset values and no `done` is issued.

## Test plan
- Reset, then `loopback`=1, mode 0, `clk_div`=4, `start` with `data_tx`=0xA5 → `done` at +69 cycles, `data_rx`=0xA5, `cs_n[0]` low for the whole transfer, 8 SCK pulses idling low.
- `loopback`=0, slave model returning 0x55 for `data_tx`=0xAA, in each of modes 0–3 → MOSI bits captured by the slave are 0xAA MSB-first; `data_rx`=0x55; SCK idle level equals CPOL.
- Push 0x01,0x02,0x03 into the TX FIFO with loopback → three `done` pulses, CS held active across all bytes, single `irq` at the end; RX FIFO reads return 0x01,0x02,0x03, then `rx_fifo_empty`=1.
- Write 9 bytes while `busy` is held off by a long first transfer → `tx_fifo_full`=1 after 8; the 9th write pulses `error`.
- `start` while `busy` → `error` pulse, the transfer in flight is unaffected; `cs_polarity`=1, `cs_select`=2 → only `cs_n[2]` goes high during the transfer.
- `reset` asserted at edge 7 of a transfer → `busy`=0, `cs_n` inactive, `done` never asserts; the next `start` completes normally.
